// File: rtl/spram_req_adapter.sv
// Valid/ready front end for a single-port synchronous RAM: forwards requests to the
// RAM's registered-address port and queues read data in a 3-entry response FIFO.
module spram_req_adapter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [14:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [14:0] ram_addr,
    output logic        ram_write_enable,
    output logic [7:0]  ram_data_in,
    input  logic [7:0]  ram_data_out
);

    localparam int unsigned DEPTH = 3;

    logic       inflight;
    logic [1:0] count;
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic [7:0] fifo_mem [0:DEPTH-1];

    logic [2:0] credits_used;
    logic       read_accept;
    logic       push;
    logic       pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
        return (ptr == 2'(DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

    // A read in flight already owns a FIFO slot, so it counts against the credit.
    assign credits_used = {1'b0, count} + {2'b00, inflight};
    assign req_ready    = rst_n & (req_write | (credits_used < 3'(DEPTH)));
    assign read_accept  = req_valid & req_ready & ~req_write;

    assign ram_addr         = req_addr;
    assign ram_data_in      = req_wdata;
    assign ram_write_enable = rst_n & req_valid & req_ready & req_write;

    assign push      = inflight;
    assign rsp_valid = (count != 2'd0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_data  = fifo_mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of the order the always blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
        end else begin
            inflight <= read_accept;
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the data array is deliberately left out of reset; count/rsp_valid gate
    // every read of it, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= ram_data_out;
    end

    overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count == 2'(DEPTH)));

endmodule

// File: tb/tb_spram_req_adapter.sv
// Self-checking bench for spram_req_adapter: behavioural RAM, a queue-based response
// model compared every cycle, and directed scenarios with literal expectations.
module tb_spram_req_adapter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [14:0] req_addr = 15'd0;
    logic [7:0]  req_wdata = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic [14:0] ram_addr;
    logic        ram_write_enable;
    logic [7:0]  ram_data_in;
    logic [7:0]  ram_data_out;

    spram_req_adapter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .ram_addr         (ram_addr),
        .ram_write_enable (ram_write_enable),
        .ram_data_in      (ram_data_in),
        .ram_data_out     (ram_data_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Preloaded RAM contents: a fixed arithmetic pattern, with 0x1235 = 0x5A.
    function automatic logic [7:0] pat(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    function automatic logic [7:0] base_word(input int a);
        return (a == 32'h1235) ? 8'h5A : pat(a);
    endfunction

    // Behavioural RAM: address sampled at the edge, read data one cycle later.
    logic [7:0] ram_wr [int];

    function automatic logic [7:0] ram_word(input int a);
        return ram_wr.exists(a) ? ram_wr[a] : base_word(a);
    endfunction

    always @(posedge clk) begin
        ram_data_out <= ram_word(int'(ram_addr));
        if (ram_write_enable) ram_wr[int'(ram_addr)] = ram_data_in;
    end

    // Response model: reads in transit (accepted, data not yet queued) and visible responses.
    logic [7:0] mdl_wr [int];
    logic [7:0] transit_q [$];
    logic [7:0] vis_q [$];
    logic [7:0] got_q [$];
    int         n_acc = 0;
    logic       saw_valid = 1'b0;

    function automatic logic [7:0] mdl_word(input int a);
        return mdl_wr.exists(a) ? mdl_wr[a] : base_word(a);
    endfunction

    always @(negedge clk) begin
        logic exp_ready;
        logic exp_valid;
        exp_valid = rst_n && (vis_q.size() != 0);
        exp_ready = rst_n && (req_write || (vis_q.size() + transit_q.size() < 3));
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) check("rsp_data", 32'(rsp_data), 32'(vis_q[0]));
        check("ram_write_enable", 32'(ram_write_enable), 32'(rst_n & req_valid & req_write));
        check("ram_addr", 32'(ram_addr), 32'(req_addr));
        check("ram_data_in", 32'(ram_data_in), 32'(req_wdata));

        if (rsp_valid) saw_valid = 1'b1;
        if (rsp_valid && rsp_ready) got_q.push_back(rsp_data);
        if (rst_n && req_valid && req_ready && !req_write) n_acc++;

        // Advance the model across the coming edge.
        if (!rst_n) begin
            vis_q.delete();
            transit_q.delete();
        end else begin
            if (exp_valid && rsp_ready) void'(vis_q.pop_front());
            if (transit_q.size() != 0) vis_q.push_back(transit_q.pop_front());
            if (req_valid && exp_ready && req_write) mdl_wr[int'(req_addr)] = req_wdata;
            if (req_valid && exp_ready && !req_write) transit_q.push_back(mdl_word(int'(req_addr)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic w, input logic [14:0] a, input logic [7:0] d, output int waited);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        waited    = 0;
        while (1) begin
            @(negedge clk);
            if (req_ready || waited >= 100) break;
            waited++;
        end
        check("req_accepted", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while ((vis_q.size() != 0 || transit_q.size() != 0) && n < 50) begin
            step();
            n++;
        end
        step();
        check("drain_empty", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int j;
        int k;

        // Reset, then release: ready must come up in the first cycle.
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);
        step();

        // Write then read the same address, then a preloaded neighbour.
        got_q.delete();
        rsp_ready = 1'b1;
        do_req(1'b1, 15'h1234, 8'hA5, w);
        do_req(1'b0, 15'h1234, 8'h00, w);
        do_req(1'b0, 15'h1235, 8'h00, w);
        drain();
        check("wr_rd_count", 32'(got_q.size()), 32'd2);
        check("wr_rd_new_data", 32'(got_q[0]), 32'h0000_00A5);
        check("wr_rd_preload", 32'(got_q[1]), 32'h0000_005A);

        // Streaming reads with the consumer always ready.
        got_q.delete();
        for (int i = 0; i < 16; i++) begin
            do_req(1'b0, 15'(i), 8'h00, w);
            check("stream_no_stall", 32'(w), 32'd0);
        end
        drain();
        check("stream_count", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) check("stream_data", 32'(got_q[i]), 32'(pat(i)));
        check("stream_first", 32'(got_q[0]), 32'h0000_000B);
        check("stream_second", 32'(got_q[1]), 32'h0000_0030);

        // Backpressure: five reads offered, only three credits.
        got_q.delete();
        rsp_ready = 1'b0;
        j = 0;
        for (int c = 0; c < 10; c++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 15'(32'h20 + j);
            @(negedge clk);
            if (req_ready) j++;
            step();
        end
        req_valid = 1'b0;
        check("bp_accepted", 32'(j), 32'd3);
        @(negedge clk);
        check("bp_read_blocked", 32'(req_ready), 32'd0);
        step();

        // A write while the FIFO is full goes straight through.
        do_req(1'b1, 15'h7FFF, 8'h3C, w);
        check("full_write_no_stall", 32'(w), 32'd0);
        @(negedge clk);
        check("still_full", 32'(req_ready), 32'd0);
        check("still_full_valid", 32'(rsp_valid), 32'd1);
        step();

        rsp_ready = 1'b1;
        do_req(1'b0, 15'h0023, 8'h00, w);
        do_req(1'b0, 15'h0024, 8'h00, w);
        do_req(1'b0, 15'h7FFF, 8'h00, w);
        drain();
        check("bp_count", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < 5; i++) check("bp_data", 32'(got_q[i]), 32'(pat(32'h20 + i)));
        check("bp_first", 32'(got_q[0]), 32'h0000_00AB);
        check("full_write_readback", 32'(got_q[5]), 32'h0000_003C);

        // Pointer wrap with a randomly stalling consumer.
        got_q.delete();
        k = 0;
        for (int c = 0; c < 300 && k < 10; c++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 15'(32'h100 + k);
            @(negedge clk);
            if (req_ready) k++;
            step();
        end
        req_valid = 1'b0;
        check("wrap_all_accepted", 32'(k), 32'd10);
        drain();
        check("wrap_count", 32'(got_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) check("wrap_data", 32'(got_q[i]), 32'(pat(32'h100 + i)));

        // Reset while a read is in flight: its response must never appear.
        rsp_ready = 1'b0;
        do_req(1'b0, 15'h0005, 8'h00, w);
        rst_n = 1'b0;
        saw_valid = 1'b0;
        step();
        @(negedge clk);
        check("rst_ready_low", 32'(req_ready), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 32'(req_ready), 32'd1);
        repeat (5) step();
        check("rst_no_response", 32'(saw_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
